// File: rtl/crc_stream_engine_if.sv
// rtl/crc_stream_engine_if.sv - config, byte-in and result handshake bundle for crc_stream_engine
//
// master : byte source / config writer / result sink side (drives cfg_*, clear, in_*, out_ready)
// slave  : the CRC engine side (drives cfg_ready, in_ready, out_valid, out_crc, busy)
interface crc_stream_engine_if #(
    parameter int MAX_WIDTH = 64,
    parameter int WBITS     = 6
);
    logic                 cfg_we;
    logic                 cfg_ready;
    logic [WBITS-1:0]     cfg_width;
    logic [MAX_WIDTH-1:0] cfg_poly;
    logic [MAX_WIDTH-1:0] cfg_init;
    logic [MAX_WIDTH-1:0] cfg_xor;
    logic                 cfg_refin;
    logic                 cfg_refout;
    logic                 clear;
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [MAX_WIDTH-1:0] out_crc;
    logic                 busy;

    modport master (
        output cfg_we, cfg_width, cfg_poly, cfg_init, cfg_xor, cfg_refin, cfg_refout,
        output clear, in_valid, in_data, in_last, out_ready,
        input  cfg_ready, in_ready, out_valid, out_crc, busy
    );

    modport slave (
        input  cfg_we, cfg_width, cfg_poly, cfg_init, cfg_xor, cfg_refin, cfg_refout,
        input  clear, in_valid, in_data, in_last, out_ready,
        output cfg_ready, in_ready, out_valid, out_crc, busy
    );
endinterface

// File: rtl/crc_stream_engine.sv
// rtl/crc_stream_engine.sv - configurable Rocksoft-model CRC over a byte stream
//
// Purpose: folds message bytes into a CRC of width 1..MAX_WIDTH, BITS_PER_CYCLE bits per clock,
//          and presents the final (reflected/xored) CRC on a held result handshake.
// Ports:   clk        rising-edge clock
//          rst        asynchronous active-low reset
//          bus.slave  cfg_* write port, clear, in_* byte stream, out_* result stream, busy
module crc_stream_engine #(
    parameter int MAX_WIDTH      = 64,
    parameter int WBITS          = 6,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    crc_stream_engine_if.slave bus
);
    localparam int S  = 8 / BITS_PER_CYCLE;
    localparam int CW = (S > 1) ? $clog2(S) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, RESULT} state_t;

    state_t               state_q, state_d;
    logic [MAX_WIDTH-1:0] crc_q, crc_d;
    logic [MAX_WIDTH-1:0] poly_q, poly_d;
    logic [MAX_WIDTH-1:0] init_q, init_d;
    logic [MAX_WIDTH-1:0] xor_q, xor_d;
    logic [MAX_WIDTH-1:0] out_crc_q, out_crc_d;
    logic [WBITS-1:0]     width_q, width_d;
    logic                 refin_q, refin_d;
    logic                 refout_q, refout_d;
    logic                 last_q, last_d;
    logic                 out_valid_q, out_valid_d;
    logic [7:0]           buf_q, buf_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic [MAX_WIDTH-1:0] mask_cur, mask_new;
    logic [MAX_WIDTH-1:0] crc_fold, crc_rev, result;
    logic [7:0]           buf_fold;
    logic                 fold_b, fold_fb;
    logic [WBITS-1:0]     rev_idx;
    logic                 in_ready_w, accept, cfg_write, last_step;

    // Bit i is set when i < W, i.e. i <= (W-1); never wraps for any W.
    function automatic logic [MAX_WIDTH-1:0] width_mask(input logic [WBITS-1:0] wm1);
        logic [MAX_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            m[i] = (WBITS'(i) <= wm1);
        end
        return m;
    endfunction

    assign mask_cur = width_mask(width_q);
    assign mask_new = width_mask(bus.cfg_width);

    // Unrolled fold of BITS_PER_CYCLE bits; the byte buffer shifts toward the
    // end being consumed so the next bit is always at a fixed position.
    always_comb begin
        crc_fold = crc_q;
        buf_fold = buf_q;
        fold_b   = 1'b0;
        fold_fb  = 1'b0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            fold_b   = refin_q ? buf_fold[0] : buf_fold[7];
            buf_fold = refin_q ? {1'b0, buf_fold[7:1]} : {buf_fold[6:0], 1'b0};
            fold_fb  = crc_fold[width_q] ^ fold_b;
            crc_fold = ((crc_fold << 1) & mask_cur) ^ (fold_fb ? poly_q : '0);
        end
    end

    // W-bit reversal of the post-fold register; bits at/above W stay zero.
    always_comb begin
        crc_rev = '0;
        rev_idx = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (WBITS'(i) <= width_q) begin
                rev_idx    = width_q - WBITS'(i);
                crc_rev[i] = crc_fold[rev_idx];
            end
        end
    end

    assign result     = ((refout_q ? crc_rev : crc_fold) ^ xor_q) & mask_cur;
    assign last_step  = (state_q == SHIFT) && (cnt_q == CW'(S - 1));
    assign in_ready_w = (state_q == IDLE) || (last_step && !last_q);
    assign accept     = bus.in_valid && in_ready_w && !bus.clear;
    assign cfg_write  = bus.cfg_we && (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        poly_d      = poly_q;
        init_d      = init_q;
        xor_d       = xor_q;
        out_crc_d   = out_crc_q;
        width_d     = width_q;
        refin_d     = refin_q;
        refout_d    = refout_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        buf_d       = buf_q;
        cnt_d       = cnt_q;

        // A config write also restarts the register, so it wins over the
        // init reload done by clear or by a same-cycle byte accept.
        if (cfg_write) begin
            width_d  = bus.cfg_width;
            poly_d   = bus.cfg_poly & mask_new;
            init_d   = bus.cfg_init & mask_new;
            xor_d    = bus.cfg_xor & mask_new;
            refin_d  = bus.cfg_refin;
            refout_d = bus.cfg_refout;
            crc_d    = bus.cfg_init & mask_new;
        end

        if (bus.clear) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            cnt_d       = '0;
            last_d      = 1'b0;
            if (!cfg_write) begin
                crc_d = init_q;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        buf_d   = bus.in_data;
                        last_d  = bus.in_last;
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    crc_d = crc_fold;
                    buf_d = buf_fold;
                    cnt_d = cnt_q + 1'b1;
                    if (last_step) begin
                        cnt_d = '0;
                        if (last_q) begin
                            state_d     = RESULT;
                            out_valid_d = 1'b1;
                            out_crc_d   = result;
                        end else if (accept) begin
                            buf_d  = bus.in_data;
                            last_d = bus.in_last;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                RESULT: begin
                    if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                        crc_d       = init_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            crc_q       <= MAX_WIDTH'(32'hFFFF_FFFF);
            poly_q      <= MAX_WIDTH'(32'h04C1_1DB7);
            init_q      <= MAX_WIDTH'(32'hFFFF_FFFF);
            xor_q       <= MAX_WIDTH'(32'hFFFF_FFFF);
            out_crc_q   <= '0;
            width_q     <= WBITS'(31);
            refin_q     <= 1'b1;
            refout_q    <= 1'b1;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            buf_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            poly_q      <= poly_d;
            init_q      <= init_d;
            xor_q       <= xor_d;
            out_crc_q   <= out_crc_d;
            width_q     <= width_d;
            refin_q     <= refin_d;
            refout_q    <= refout_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.cfg_ready = (state_q == IDLE);
    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_crc   = out_crc_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
